// File: rtl/bit_index_encoder_pkg.sv
// rtl/bit_index_encoder_pkg.sv - shared types and bit-scan helpers for bit_index_encoder
package bit_index_encoder_pkg;

    typedef enum logic {IDLE, SCAN} enc_state_t;

    // Helpers take a fixed-width vector; callers zero-extend their N-bit vector.
    localparam int MAX_N = 128;

    function automatic int lowest_set_index(input logic [MAX_N-1:0] v);
        int idx;
        idx = 0;
        for (int i = MAX_N - 1; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

    function automatic logic is_single_bit(input logic [MAX_N-1:0] v);
        return (v != '0) && ((v & (v - MAX_N'(1))) == '0);
    endfunction

endpackage

// File: rtl/bit_index_encoder_if.sv
// rtl/bit_index_encoder_if.sv - input/output handshake bundle; out_count with BIT_INDEX_ENCODER_COUNT_EN
interface bit_index_encoder_if #(
    parameter int N = 16
);
    localparam int W = $clog2(N);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_bits;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_index;
    logic         out_last;
    logic         busy;
`ifdef BIT_INDEX_ENCODER_COUNT_EN
    logic [W:0]   out_count;
`endif

    modport slave (
        input  in_valid, in_bits, out_ready,
        output in_ready, out_valid, out_index, out_last, busy
`ifdef BIT_INDEX_ENCODER_COUNT_EN
        , output out_count
`endif
    );

    modport master (
        output in_valid, in_bits, out_ready,
        input  in_ready, out_valid, out_index, out_last, busy
`ifdef BIT_INDEX_ENCODER_COUNT_EN
        , input out_count
`endif
    );

endinterface

// File: rtl/bit_index_encoder_priority.sv
// rtl/bit_index_encoder_priority.sv - combinational lowest-set-bit encoder
module priority_encoder_lsb
    import bit_index_encoder_pkg::*;
#(
    parameter  int N = 16,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    assign idx = W'(lowest_set_index(MAX_N'(vec)));
    assign any = (vec != '0);

endmodule

// File: rtl/bit_index_encoder.sv
// rtl/bit_index_encoder.sv - serialises set-bit indices of a vector, lowest first
// Optional out_count popcount port enabled by BIT_INDEX_ENCODER_COUNT_EN.
module bit_index_encoder
    import bit_index_encoder_pkg::*;
#(
    parameter  int N = 16,
    localparam int W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    bit_index_encoder_if.slave bus
);

    enc_state_t   state_q;
    logic [N-1:0] pending_q;
    logic [N-1:0] pending_d;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         busy_q;
    logic [W-1:0] enc_idx;
    logic         enc_any;
    logic         last_w;
`ifdef BIT_INDEX_ENCODER_COUNT_EN
    logic [W:0]   count_q;
`endif

    priority_encoder_lsb #(.N(N)) u_enc (
        .vec (pending_q),
        .idx (enc_idx),
        .any (enc_any)
    );

    // Handshake retires the lowest set bit, which is exactly the one on out_index.
    assign pending_d = pending_q & (pending_q - N'(1));
    assign last_w    = (state_q == SCAN) && is_single_bit(MAX_N'(pending_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef BIT_INDEX_ENCODER_COUNT_EN
            count_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        pending_q <= bus.in_bits;
`ifdef BIT_INDEX_ENCODER_COUNT_EN
                        count_q   <= (W+1)'($countones(bus.in_bits));
`endif
                        if (bus.in_bits != '0) begin
                            state_q     <= SCAN;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            busy_q      <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (bus.out_ready) begin
                        pending_q <= pending_d;
                        if (last_w || !enc_any) begin
                            state_q     <= IDLE;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.out_index = enc_idx;
    assign bus.out_last  = last_w;
`ifdef BIT_INDEX_ENCODER_COUNT_EN
    assign bus.out_count = count_q;
`endif

endmodule

// File: tb/tb_bit_index_encoder.sv
// tb/tb_bit_index_encoder.sv - self-checking bench for bit_index_encoder
module tb_bit_index_encoder;

    localparam int N = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bit_index_encoder_if #(.N(16)) bus ();
    bit_index_encoder_if #(.N(4))  bus4 ();

    bit_index_encoder #(.N(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    bit_index_encoder #(.N(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    int   tests = 0;
    int   fails = 0;
    logic cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: a vector becomes the queue of its set-bit indices; one pops per accepted output.
    int q[$];
    int m_count = 0;

    always @(negedge rst_n) begin
        q.delete();
        m_count = 0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (q.size() != 0) begin
                if (bus.out_ready) void'(q.pop_front());
            end else if (bus.in_valid) begin
                m_count = 0;
                for (int i = 0; i < N; i++) begin
                    if (bus.in_bits[i]) begin
                        q.push_back(i);
                        m_count++;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            check("out_valid", bus.out_valid, q.size() != 0);
            check("in_ready",  bus.in_ready,  q.size() == 0);
            check("busy",      bus.busy,      q.size() != 0);
            check("out_last",  bus.out_last,  q.size() == 1);
            if (q.size() != 0) check("out_index", bus.out_index, q[0]);
`ifdef BIT_INDEX_ENCODER_COUNT_EN
            check("out_count", bus.out_count, m_count);
`endif
        end
    end

    int log_q[$];
    always @(negedge clk) begin
        #2;
        if (rst_n && bus.out_valid && bus.out_ready) log_q.push_back(int'(bus.out_index));
    end

    task automatic send(input logic [N-1:0] b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_bits  = b;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("send_timeout", 0, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(bus.in_ready && !bus.out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    int e8421[4];
    int eb2b[3];

    initial begin
        e8421 = '{0, 5, 10, 15};
        eb2b  = '{0, 1, 8};
        bus.in_valid   = 1'b0;
        bus.in_bits    = '0;
        bus.out_ready  = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.in_bits   = '0;
        bus4.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_in_ready",  bus.in_ready,  1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_index", bus.out_index, 0);
        check("rst_out_last",  bus.out_last,  0);
        check("rst_busy",      bus.busy,      0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        log_q.delete();
        send(16'h0000);
        repeat (3) @(negedge clk);
        check("zero_in_ready",  bus.in_ready,  1);
        check("zero_out_valid", bus.out_valid, 0);
        check("zero_emitted",   log_q.size(),  0);
`ifdef BIT_INDEX_ENCODER_COUNT_EN
        check("zero_count", bus.out_count, 0);
`endif

        log_q.delete();
        send(16'h8421);
        wait_idle();
        check("p8421_len", log_q.size(), 4);
        for (int k = 0; k < 4 && k < log_q.size(); k++) check("p8421_idx", log_q[k], e8421[k]);
`ifdef BIT_INDEX_ENCODER_COUNT_EN
        check("p8421_count", bus.out_count, 4);
`endif

        log_q.delete();
        send(16'hFFFF);
        for (int i = 0; i < 40; i++) begin
            bus.out_ready = (i % 2 == 0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        wait_idle();
        check("ffff_len", log_q.size(), 16);
        for (int k = 0; k < 16 && k < log_q.size(); k++) check("ffff_idx", log_q[k], k);

        log_q.delete();
        send(16'h0003);
        send(16'h0100);
        wait_idle();
        check("b2b_len", log_q.size(), 3);
        for (int k = 0; k < 3 && k < log_q.size(); k++) check("b2b_idx", log_q[k], eb2b[k]);

        send(16'hFFFF);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_in_ready",  bus.in_ready,  1);
        check("mid_rst_busy",      bus.busy,      0);
        repeat (2) @(negedge clk);
        check("held_rst_out_valid", bus.out_valid, 0);
        check("held_rst_out_index", bus.out_index, 0);
        rst_n = 1'b1;
        log_q.delete();
        repeat (5) @(negedge clk);
        check("post_rst_emitted",  log_q.size(),  0);
        check("post_rst_in_ready", bus.in_ready,  1);

        bus4.in_bits  = 4'b1000;
        bus4.in_valid = 1'b1;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        check("n4_out_valid", bus4.out_valid, 1);
        check("n4_out_index", bus4.out_index, 3);
        check("n4_out_last",  bus4.out_last,  1);
        check("n4_busy",      bus4.busy,      1);
`ifdef BIT_INDEX_ENCODER_COUNT_EN
        check("n4_count", bus4.out_count, 1);
`endif
        @(negedge clk);
        check("n4_done_valid", bus4.out_valid, 0);
        check("n4_done_ready", bus4.in_ready,  1);

        cmp_en = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
